// File: rtl/npn_pkg.sv
// rtl/npn_pkg.sv - shared types, constants and helpers for the NPN sweep sequencer
package npn_pkg;

  localparam int N_IN = 4;
  localparam int TT_W = 1 << N_IN;
  localparam logic [7:0] IDENT_PERM = 8'hE4;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    SWEEP,
    RESULT
  } state_e;

  // idx[i] names the minterm bit that feeds target input i
  typedef struct packed {
    logic [N_IN-1:0][1:0] idx;
  } perm_t;

  function automatic logic perm_is_bijective(perm_t p);
    logic [N_IN-1:0] seen;
    seen = '0;
    for (int i = 0; i < N_IN; i++) begin
      seen[p.idx[i]] = 1'b1;
    end
    return &seen;
  endfunction

endpackage

// File: rtl/npn_sweep_ctrl_if.sv
// rtl/npn_sweep_ctrl_if.sv - config, evaluation and result signals of the sweep sequencer
interface npn_sweep_ctrl_if;
  import npn_pkg::*;

  logic            cfg_valid;
  logic            cfg_ready;
  logic [7:0]      cfg_perm;
  logic [N_IN-1:0] cfg_neg_in;
  logic            cfg_neg_out;
  logic [N_IN-1:0] eval_x;
  logic            eval_y;
  logic            res_valid;
  logic            res_ready;
  logic [TT_W-1:0] res_tt;
  logic            res_err;
  logic            busy;

  modport master (
    output cfg_valid, cfg_perm, cfg_neg_in, cfg_neg_out, res_ready, eval_y,
    input  cfg_ready, eval_x, res_valid, res_tt, res_err, busy
  );

  modport slave (
    input  cfg_valid, cfg_perm, cfg_neg_in, cfg_neg_out, res_ready, eval_y,
    output cfg_ready, eval_x, res_valid, res_tt, res_err, busy
  );

endinterface

// File: rtl/npn_vec_xform.sv
// rtl/npn_vec_xform.sv - maps a minterm through the input permutation and negation mask
module npn_vec_xform
  import npn_pkg::*;
(
  input  logic [3:0]      m_i,
  input  perm_t           perm_i,
  input  logic [N_IN-1:0] neg_in_i,
  output logic [N_IN-1:0] x_o
);

  always_comb begin
    x_o = '0;
    for (int i = 0; i < N_IN; i++) begin
      x_o[i] = m_i[perm_i.idx[i]] ^ neg_in_i[i];
    end
  end

endmodule

// File: rtl/npn_sweep_ctrl.sv
// rtl/npn_sweep_ctrl.sv - sweeps all 16 minterms through an NPN transform and assembles the truth table
module npn_sweep_ctrl
  import npn_pkg::*;
#(
  parameter int EVAL_LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  npn_sweep_ctrl_if.slave  bus
);

  state_e          state_q, state_d;
  perm_t           perm_q;
  logic [N_IN-1:0] neg_in_q;
  logic            neg_out_q;
  logic [4:0]      m_q;
  logic [TT_W-1:0] tt_q;
  logic            err_q;
  logic            perm_ok;
  logic            issue;
  logic            cap_v;
  logic [3:0]      cap_m;
  logic [N_IN-1:0] xf_x;

  assign perm_ok = perm_is_bijective(perm_q);
  assign issue   = (state_q == SWEEP) && !m_q[4];

  npn_vec_xform u_xform (
    .m_i      (m_q[3:0]),
    .perm_i   (perm_q),
    .neg_in_i (neg_in_q),
    .x_o      (xf_x)
  );

  // Issue tokens travel alongside the target's latency so each sample lands on its own minterm
  generate
    if (EVAL_LAT == 0) begin : g_nodly
      assign cap_v = issue;
      assign cap_m = m_q[3:0];
    end else begin : g_dly
      logic [EVAL_LAT-1:0] dl_v_q;
      logic [3:0]          dl_m_q [EVAL_LAT];

      always_ff @(posedge clk) begin
        if (rst) begin
          dl_v_q <= '0;
          for (int k = 0; k < EVAL_LAT; k++) dl_m_q[k] <= '0;
        end else begin
          dl_v_q[0] <= issue;
          dl_m_q[0] <= m_q[3:0];
          for (int k = 1; k < EVAL_LAT; k++) begin
            dl_v_q[k] <= dl_v_q[k-1];
            dl_m_q[k] <= dl_m_q[k-1];
          end
        end
      end

      assign cap_v = dl_v_q[EVAL_LAT-1];
      assign cap_m = dl_m_q[EVAL_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.cfg_valid) state_d = CHECK;
      CHECK:   state_d = perm_ok ? SWEEP : RESULT;
      SWEEP:   if (cap_v && (cap_m == 4'd15)) state_d = RESULT;
      RESULT:  if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.cfg_ready = 1'b0;
    bus.busy      = 1'b1;
    bus.res_valid = 1'b0;
    bus.eval_x    = '0;
    bus.res_tt    = tt_q;
    bus.res_err   = err_q;
    case (state_q)
      IDLE: begin
        bus.cfg_ready = 1'b1;
        bus.busy      = 1'b0;
      end
      SWEEP:   bus.eval_x = issue ? xf_x : '0;
      RESULT:  bus.res_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perm_q    <= perm_t'(IDENT_PERM);
      neg_in_q  <= '0;
      neg_out_q <= 1'b0;
      m_q       <= '0;
      tt_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cfg_valid) begin
            perm_q    <= perm_t'(bus.cfg_perm);
            neg_in_q  <= bus.cfg_neg_in;
            neg_out_q <= bus.cfg_neg_out;
          end
        end
        CHECK: begin
          m_q   <= '0;
          tt_q  <= '0;
          err_q <= !perm_ok;
        end
        SWEEP: begin
          if (!m_q[4]) m_q <= m_q + 5'd1;
          if (cap_v)   tt_q[cap_m] <= bus.eval_y ^ neg_out_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_npn_sweep_ctrl.sv
// tb/tb_npn_sweep_ctrl.sv - randomized and directed checks of npn_sweep_ctrl at EVAL_LAT 0 and 2
module tb_npn_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic [7:0]  cfg_perm;
  logic [3:0]  cfg_neg_in;
  logic        cfg_neg_out;
  logic        res_ready;
  logic [15:0] tgt_f;
  logic        y1, y2;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  npn_sweep_ctrl_if if0();
  npn_sweep_ctrl_if if2();

  assign if0.cfg_valid = cfg_valid;   assign if2.cfg_valid = cfg_valid;
  assign if0.cfg_perm = cfg_perm;     assign if2.cfg_perm = cfg_perm;
  assign if0.cfg_neg_in = cfg_neg_in; assign if2.cfg_neg_in = cfg_neg_in;
  assign if0.cfg_neg_out = cfg_neg_out; assign if2.cfg_neg_out = cfg_neg_out;
  assign if0.res_ready = res_ready;   assign if2.res_ready = res_ready;

  assign if0.eval_y = tgt_f[if0.eval_x];
  always @(posedge clk) begin
    y1 <= tgt_f[if2.eval_x];
    y2 <= y1;
  end
  assign if2.eval_y = y2;

  npn_sweep_ctrl #(.EVAL_LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  npn_sweep_ctrl #(.EVAL_LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  logic        o_rdy [2], o_busy [2], o_rv [2], o_err [2];
  logic [3:0]  o_x [2];
  logic [15:0] o_tt [2];
  assign o_rdy[0] = if0.cfg_ready; assign o_rdy[1] = if2.cfg_ready;
  assign o_busy[0] = if0.busy;     assign o_busy[1] = if2.busy;
  assign o_rv[0] = if0.res_valid;  assign o_rv[1] = if2.res_valid;
  assign o_err[0] = if0.res_err;   assign o_err[1] = if2.res_err;
  assign o_x[0] = if0.eval_x;      assign o_x[1] = if2.eval_x;
  assign o_tt[0] = if0.res_tt;     assign o_tt[1] = if2.res_tt;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", name, d, $time, act, exp);
    end
  endtask

  function automatic int lat(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic logic [3:0] bxf(input int m, input logic [7:0] p, input logic [3:0] ni);
    logic [3:0] x;
    logic [3:0] mm;
    logic [1:0] src;
    mm = m[3:0];
    x  = '0;
    for (int i = 0; i < 4; i++) begin
      src  = p[2*i +: 2];
      x[i] = mm[src] ^ ni[i];
    end
    return x;
  endfunction

  function automatic bit blegal(input logic [7:0] p);
    int cnt [4];
    for (int v = 0; v < 4; v++) cnt[v] = 0;
    for (int i = 0; i < 4; i++) cnt[p[2*i +: 2]]++;
    return (cnt[0] == 1) && (cnt[1] == 1) && (cnt[2] == 1) && (cnt[3] == 1);
  endfunction

  // Reference model: per DUT, t = cycles since the config was accepted (-1 when idle)
  int          mt [2] = '{-1, -1};
  logic [7:0]  mp [2];
  logic [3:0]  mni [2];
  bit          mlg [2];
  logic [15:0] mtt [2];
  bit          model_ok = 0;

  function automatic int rstart(input int d);
    return mlg[d] ? (18 + lat(d)) : 2;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mt[d] = -1;
      end else if (mt[d] < 0) begin
        if (cfg_valid) begin
          mt[d]  = 1;
          mp[d]  = cfg_perm;
          mni[d] = cfg_neg_in;
          mlg[d] = blegal(cfg_perm);
          mtt[d] = '0;
          if (mlg[d])
            for (int m = 0; m < 16; m++) mtt[d][m] = tgt_f[bxf(m, cfg_perm, cfg_neg_in)] ^ cfg_neg_out;
        end
      end else if (mt[d] >= rstart(d) && res_ready) begin
        mt[d] = -1;
      end else begin
        mt[d] = mt[d] + 1;
      end
    end
    if (rst) model_ok = 1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      for (int d = 0; d < 2; d++) begin
        int t;
        t = mt[d];
        if (t < 0) begin
          chk("cfg_ready", d, o_rdy[d], 1);
          chk("busy", d, o_busy[d], 0);
          chk("res_valid", d, o_rv[d], 0);
          chk("eval_x", d, o_x[d], 0);
        end else begin
          chk("cfg_ready", d, o_rdy[d], 0);
          chk("busy", d, o_busy[d], 1);
          if (t >= rstart(d)) begin
            chk("res_valid", d, o_rv[d], 1);
            chk("res_tt", d, o_tt[d], mtt[d]);
            chk("res_err", d, o_err[d], !mlg[d]);
            chk("eval_x", d, o_x[d], 0);
          end else begin
            chk("res_valid", d, o_rv[d], 0);
            chk("eval_x", d, o_x[d], (t >= 2 && t - 2 < 16) ? bxf(t - 2, mp[d], mni[d]) : 4'h0);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // mode 0: res_ready held high, 1: random res_ready and stray configs, 2: leave both in RESULT
  task automatic run(input logic [7:0] p, input logic [3:0] ni, input logic no, input logic [15:0] f,
                     input int mode, input bit lit, input logic [15:0] ltt, input logic lerr);
    int n;
    bit got [2];
    tgt_f = f;
    cfg_perm = p; cfg_neg_in = ni; cfg_neg_out = no; cfg_valid = 1'b1;
    res_ready = (mode == 0);
    tick();
    cfg_valid = 1'b0;
    n = 1;
    got[0] = 0; got[1] = 0;
    while (n < 200) begin
      for (int d = 0; d < 2; d++) begin
        if (o_rv[d] && !got[d]) begin
          got[d] = 1;
          chk("latency", d, n, blegal(p) ? (18 + lat(d)) : 2);
          if (lit) begin
            chk("lit_tt", d, o_tt[d], ltt);
            chk("lit_err", d, o_err[d], lerr);
          end
        end
      end
      if (got[0] && got[1] && (mode == 2 || (o_rdy[0] && o_rdy[1]))) break;
      if (mode == 1) begin
        res_ready = 1'($urandom_range(0, 1));
        if (mt[0] >= 1 && mt[1] >= 1 && $urandom_range(0, 3) == 0) begin
          cfg_valid = 1'b1;
          cfg_perm = 8'($urandom); cfg_neg_in = 4'($urandom); cfg_neg_out = 1'($urandom);
        end else begin
          cfg_valid = 1'b0;
        end
      end
      tick();
      n++;
    end
    cfg_valid = 1'b0;
    if (n >= 200) begin
      n_tests++; n_fail++;
      $display("FAIL timeout mode=%0d actual=%0d cycles required=<200", mode, n);
    end
  endtask

  function automatic logic [7:0] rand_perm();
    logic [1:0] a [4];
    logic [1:0] tmp;
    int j;
    for (int i = 0; i < 4; i++) a[i] = 2'(i);
    for (int i = 3; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = a[i]; a[i] = a[j]; a[j] = tmp;
    end
    return {a[3], a[2], a[1], a[0]};
  endfunction

  initial begin
    int k;
    rst = 1'b1; cfg_valid = 1'b0; cfg_perm = '0; cfg_neg_in = '0; cfg_neg_out = 1'b0;
    res_ready = 1'b1; tgt_f = 16'h177E;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_tt", d, o_tt[d], 0);
      chk("rst_err", d, o_err[d], 0);
    end
    rst = 1'b0;

    run(8'hE4, 4'b0000, 1'b0, 16'h177E, 0, 1, 16'h177E, 1'b0);
    run(8'hE4, 4'b0000, 1'b1, 16'h177E, 0, 1, 16'hE881, 1'b0);
    run(8'hE4, 4'b0001, 1'b0, 16'h177E, 0, 1, 16'h2BBD, 1'b0);
    run(8'hE0, 4'b0000, 1'b0, 16'h177E, 0, 1, 16'h0000, 1'b1);

    run(8'hE4, 4'b0000, 1'b0, 16'h177E, 2, 1, 16'h177E, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cfg_valid = (i == 1);
      cfg_perm = 8'h1B; cfg_neg_in = 4'hF; cfg_neg_out = 1'b1;
      tick();
      for (int d = 0; d < 2; d++) begin
        chk("bp_valid", d, o_rv[d], 1);
        chk("bp_tt", d, o_tt[d], 16'h177E);
        chk("bp_cfg_ready", d, o_rdy[d], 0);
      end
    end
    cfg_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) chk("bp_release", d, o_rdy[d], 1);

    cfg_perm = 8'hE4; cfg_neg_in = 4'h0; cfg_neg_out = 1'b0; tgt_f = 16'h177E;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    k = 0;
    while (mt[0] != 9 && k < 50) begin
      tick();
      k++;
    end
    chk("rst_sweep_x7", 0, o_x[0], 7);
    rst = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      chk("mid_rst_ready", d, o_rdy[d], 1);
      chk("mid_rst_valid", d, o_rv[d], 0);
      chk("mid_rst_x", d, o_x[d], 0);
    end
    rst = 1'b0;
    run(8'hE4, 4'b0000, 1'b0, 16'h177E, 0, 1, 16'h177E, 1'b0);

    for (int r = 0; r < 25; r++) begin
      logic [7:0] p;
      p = ($urandom_range(0, 3) == 0) ? 8'($urandom) : rand_perm();
      run(p, 4'($urandom), 1'($urandom), 16'($urandom), 1, 0, 16'h0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
